// File: rtl/sk6812_tx.sv
// sk6812_tx: 6502-bus FIFO-fed SK6812 one-wire LED transmitter.
// Bytes go out MSB first, back to back, and each frame ends with a latch low period.
module sk6812_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int T0H_CYC    = 4,
  parameter int T1H_CYC    = 7,
  parameter int BIT_CYC    = 15,
  parameter int LATCH_CYC  = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_phi2,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_rw,
  input  logic       i_en,
  output logic [7:0] o_data,
  output logic       o_sk6812_data,
  output logic       o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int CNT_MAX = BIT_CYC > LATCH_CYC ? BIT_CYC : LATCH_CYC;
  localparam int NW = $clog2(CNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d, hi_end, lo_end;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, rd_val;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic phi2_q, sk_q, sk_d, ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d;
  logic wr, rd, push, pop, flush, empty, full, busy;
  assign empty = count_q == '0;
  assign full = count_q == CW'(FIFO_DEPTH);
  assign busy = state_q != IDLE;
  assign o_data = data_q;
  assign o_sk6812_data = sk_q;
  assign o_irq = irq_en_q && empty && !busy;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    sk_d = sk_q;
    pop = 1'b0;
    hi_end = sh_q[7] ? NW'(T1H_CYC - 1) : NW'(T0H_CYC - 1);
    lo_end = sh_q[7] ? NW'(BIT_CYC - T1H_CYC - 1) : NW'(BIT_CYC - T0H_CYC - 1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = en_q && !empty ? LOAD : IDLE;
      end
      LOAD: begin
        cnt_d = '0;
        pop = !empty;
        sh_d = mem_q[rp_q];
        idx_d = 3'd7;
        sk_d = !empty;
        state_d = empty ? IDLE : HIGH;
      end
      HIGH: if (cnt_q == hi_end) begin
        cnt_d = '0;
        sk_d = 1'b0;
        state_d = LOW;
      end
      LOW: if (cnt_q == lo_end) begin
        cnt_d = '0;
        // next bit, next byte with no gap, or end of frame
        if (idx_q != 3'd0) begin
          sh_d = {sh_q[6:0], 1'b0};
          idx_d = idx_q - 1'b1;
          sk_d = 1'b1;
          state_d = HIGH;
        end else if (en_q && !empty) begin
          pop = 1'b1;
          sh_d = mem_q[rp_q];
          idx_d = 3'd7;
          sk_d = 1'b1;
          state_d = HIGH;
        end else begin
          state_d = LATCH;
        end
      end
      LATCH: if (cnt_q == NW'(LATCH_CYC - 1)) begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr = !i_phi2 && phi2_q && !i_rw && i_en;
    rd = i_phi2 && !phi2_q && i_rw && i_en;
    flush = wr && i_addr == 4'd3 && i_data[2];
    push = wr && i_addr == 4'd0 && !full && !flush;
    rd_val = i_addr == 4'd1 ? {4'b0, ovf_q, empty, full, busy} :
             i_addr == 4'd2 ? 8'(count_q) :
             i_addr == 4'd3 ? {6'b0, irq_en_q, en_q} : 8'h00;
    data_d = rd ? rd_val : data_q;
    ovf_d = wr && i_addr == 4'd0 && full ? 1'b1 : rd && i_addr == 4'd1 ? 1'b0 : ovf_q;
    en_d = wr && i_addr == 4'd3 ? i_data[0] : en_q;
    irq_en_d = wr && i_addr == 4'd3 ? i_data[1] : irq_en_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wp_d = flush ? '0 : push ? wp_q + 1'b1 : wp_q;
    rp_d = flush ? '0 : pop ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wp_q] <= i_data;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      sk_q <= 1'b0;
      phi2_q <= 1'b0;
      data_q <= '0;
      ovf_q <= 1'b0;
      en_q <= 1'b0;
      irq_en_q <= 1'b0;
      count_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      sk_q <= sk_d;
      phi2_q <= i_phi2;
      data_q <= data_d;
      ovf_q <= ovf_d;
      en_q <= en_d;
      irq_en_q <= irq_en_d;
      count_q <= count_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
endmodule

// File: tb/tb_sk6812_tx.sv
// tb_sk6812_tx: scoreboard bench for sk6812_tx with a queue-based FIFO/bit-stream reference.
`timescale 1ns/1ps
module tb_sk6812_tx;
  localparam int DEPTH = 16, T0 = 4, T1 = 7, BITC = 15, LATCHC = 1000;
  logic clk = 0, reset_n = 0, phi2 = 0, rw = 1, en = 0;
  logic [3:0] addr = 0;
  logic [7:0] data = 0, o_data;
  logic sk, irq;
  int cyc = 0, checks = 0, fails = 0;
  logic [7:0] mfifo[$];
  logic movf = 0;
  logic [1:0] mctrl = 0;
  int exp_bits[$];
  logic [7:0] rd_exp[$];
  string rd_name[$];
  logic phi2_p = 0, rd_latched = 0, sk_p = 0, irq_p = 0, mon_en = 1, saw_high = 0;
  int last_rise = -100000, last_fall = -100000, frame_start = -1, irq_rise = -1;
  int falls = 0, frames = 0, mb = 0, commit_cyc = 0;

  sk6812_tx dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_phi2(phi2), .i_addr(addr), .i_data(data),
    .i_rw(rw), .i_en(en), .o_data(o_data), .o_sk6812_data(sk), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_write(input logic [7:0] b);
    if (mfifo.size() == DEPTH) movf = 1;
    else mfifo.push_back(b);
  endtask

  task automatic m_start();
    logic [7:0] b;
    b = mfifo.pop_front();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(int'(b[i]));
  endtask

  task automatic bus(input logic rw_i, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data = d; rw = rw_i; en = 1; phi2 = 1;
    repeat (2) @(negedge clk);
    phi2 = 0;
    @(negedge clk);
    commit_cyc = cyc;
    en = 0; rw = 1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    if (a == 0) m_write(d);
    if (a == 3) begin
      mctrl = d[1:0];
      if (d[2]) mfifo.delete();
    end
    bus(0, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input string name);
    logic [7:0] e;
    e = a == 1 ? {4'b0, movf, mfifo.size() == 0, mfifo.size() == DEPTH, 1'b0} :
        a == 2 ? 8'(mfifo.size()) : a == 3 ? {6'b0, mctrl} : 8'h00;
    if (a == 1) movf = 0;
    rd_exp.push_back(e);
    rd_name.push_back(name);
    bus(1, a, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000 && exp_bits.size() != 0; i++) @(negedge clk);
    chk("tx_bits_left", exp_bits.size(), 0);
    repeat (BITC + LATCHC + 10) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    phi2_p <= phi2;
    rd_latched <= phi2 && !phi2_p && rw && en;
  end

  // monitor: bus read data and serial pulse train against the queues
  always @(negedge clk) begin
    if (rd_latched) begin
      if (rd_exp.size() == 0) chk("unexpected_read", 1, 0);
      else chk(rd_name.pop_front(), int'(o_data), int'(rd_exp.pop_front()));
    end
    if (irq && !irq_p) irq_rise = cyc;
    irq_p = irq;
    if (sk || irq) saw_high = 1;
    if (mon_en) begin
      if (sk && !sk_p) begin
        if (cyc - last_fall < BITC) chk("bit_period", cyc - last_rise, BITC);
        else begin
          chk("latch_gap_ok", int'(cyc - last_fall >= LATCHC), 1);
          frame_start = cyc;
          frames++;
        end
        last_rise = cyc;
      end
      if (!sk && sk_p) begin
        falls++;
        if (exp_bits.size() == 0) chk("unexpected_pulse", cyc - last_rise, 0);
        else begin
          mb = exp_bits.pop_front();
          chk(mb != 0 ? "high_width_1" : "high_width_0", cyc - last_rise, mb != 0 ? T1 : T0);
        end
        last_fall = cyc;
      end
    end
    sk_p = sk;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int f0, c0;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    reset_n = 1;
    rd(0, "reset_data"); rd(1, "reset_status"); rd(2, "reset_level"); rd(3, "reset_ctrl");
    repeat (3) @(negedge clk);
    chk("idle_outputs_quiet", int'(saw_high), 0);

    wr(3, 8'h03);
    wr(0, 8'hA5); m_start();
    c0 = commit_cyc;
    wait_done();
    chk("first_rise_latency", frame_start - c0, 2);
    chk("latch_to_idle", irq_rise - last_fall, BITC - T1 + LATCHC);
    rd(1, "status_after_frame");
    wr(3, 8'h01);

    f0 = frames;
    wr(0, 8'hFF); m_start();
    wr(0, 8'h00); wr(0, 8'h81);
    rd(2, "level_mid_frame");
    m_start(); m_start();
    wait_done();
    chk("frames_3byte", frames - f0, 1);
    rd(2, "level_after_3byte");

    for (int r = 0; r < 3; r++) begin
      f0 = frames;
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        wr(0, b);
        if (k == 0) m_start();
      end
      m_start(); m_start();
      wait_done();
      chk("frames_random", frames - f0, 1);
    end

    wr(3, 8'h00);
    for (int k = 0; k < 17; k++) wr(0, 8'($urandom));
    rd(2, "level_full");
    rd(1, "status_overflow");
    rd(1, "status_overflow_cleared");
    wr(3, 8'h04);
    rd(2, "level_after_flush");

    wr(3, 8'h01);
    wr(0, 8'($urandom)); m_start();
    for (int k = 0; k < 3; k++) wr(0, 8'($urandom));
    f0 = falls;
    for (int i = 0; i < 200 && falls - f0 < 3 - 0; i++) @(negedge clk);
    wr(3, 8'h05);
    wait_done();
    repeat (100) @(negedge clk);
    rd(2, "level_after_midflush");
    rd(3, "ctrl_after_midflush");
    rd(1, "status_after_midflush");

    wr(0, 8'hFF); m_start();
    for (int i = 0; i < 50 && !sk; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    mon_en = 0;
    #1 chk("reset_forces_low", int'(sk), 0);
    exp_bits.delete(); mfifo.delete(); movf = 0; mctrl = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    sk_p = 0; last_fall = -100000; mon_en = 1;
    rd(1, "status_after_reset"); rd(2, "level_after_reset"); rd(3, "ctrl_after_reset");
    chk("irq_after_reset", int'(irq), 0);
    wr(3, 8'h01);
    wr(0, 8'h80); m_start();
    wait_done();
    chk("reads_pending", rd_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
